lsu_bridge: RTL and testbench

- Load/store unit between the execute stage's memory request and the data SRAM port. It is the downstream consumer of the core's memory interface.
- Latches one load/store request and checks alignment and opcode legality.
- Drives an aligned SRAM access with byte mask and lane-shifted write data, then waits for ack with a timeout.
- Returns sign- or zero-extended load data and stalls the pipeline via hold_o while the access is outstanding.

---
 rtl/lsu_bridge.sv | 182 ++++++++++++++++++
 tb/tb_lsu_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bridge.sv
// rtl/lsu_bridge.sv - load/store bridge from execute-stage memory request to data SRAM port
module lsu_bridge #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              req_wen_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              hold_o,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              err_o,
    output logic              mem_sel_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_wmask_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        mask_q;
    logic [31:0]       wdata_q;
    logic              wen_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [31:0]       rdata_q;

    logic              req_ok;
    logic [3:0]        req_mask;
    logic [31:0]       req_lane_data;
    logic [31:0]       load_ext;
    logic              timeout_hit;

    // Request decode: opcode legality, alignment, store lane mask and replicated data
    always_comb begin
        logic f3_ok;
        logic misalign;
        f3_ok    = 1'b0;
        misalign = 1'b0;
        if (req_wen_i) begin
            f3_ok = (req_funct3_i[2] == 1'b0) && (req_funct3_i[1:0] != 2'b11);
        end else begin
            f3_ok = (req_funct3_i[1:0] != 2'b11) && !(req_funct3_i[2] && req_funct3_i[1]);
        end
        case (req_funct3_i[1:0])
            2'b01:   misalign = req_addr_i[0];
            2'b10:   misalign = (req_addr_i[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
        req_ok = f3_ok && !misalign;

        req_mask      = 4'b0000;
        req_lane_data = req_wdata_i;
        case (req_funct3_i[1:0])
            2'b00: begin
                req_mask      = 4'b0001 << req_addr_i[1:0];
                req_lane_data = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                req_mask      = 4'b0011 << req_addr_i[1:0];
                req_lane_data = {2{req_wdata_i[15:0]}};
            end
            default: begin
                req_mask      = 4'b1111;
                req_lane_data = req_wdata_i;
            end
        endcase
        if (!req_wen_i) begin
            req_mask = 4'b0000;
        end
    end

    // Load lane selection and sign/zero extension using the latched offset
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        case (off_q)
            2'd0:    lane_b = mem_rdata_i[7:0];
            2'd1:    lane_b = mem_rdata_i[15:8];
            2'd2:    lane_b = mem_rdata_i[23:16];
            default: lane_b = mem_rdata_i[31:24];
        endcase
        lane_h = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'd0, lane_b};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = mem_rdata_i;
        endcase
    end

    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack in the timeout cycle still completes the access
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_nxt = req_ok ? S_WAIT : S_ERR;
                end
            end
            S_WAIT: begin
                if (mem_ack_i) begin
                    state_nxt = S_DONE;
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch, wait counter and load-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 8'd0;
            addr_q   <= '0;
            mask_q   <= 4'd0;
            wdata_q  <= 32'd0;
            wen_q    <= 1'b0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            rdata_q  <= 32'd0;
        end else begin
            if (state == S_IDLE && req_valid_i && req_ok) begin
                cnt      <= 8'd0;
                addr_q   <= {req_addr_i[ADDR_W-1:2], 2'b00};
                mask_q   <= req_mask;
                wdata_q  <= req_wen_i ? req_lane_data : 32'd0;
                wen_q    <= req_wen_i;
                funct3_q <= req_funct3_i;
                off_q    <= req_addr_i[1:0];
            end else if (state == S_WAIT) begin
                if (mem_ack_i) begin
                    rdata_q <= wen_q ? 32'd0 : load_ext;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

    assign hold_o       = ((state == S_IDLE) && req_valid_i) || (state == S_WAIT);
    assign mem_sel_o    = (state == S_WAIT);
    assign mem_wen_o    = (state == S_WAIT) && wen_q;
    assign mem_addr_o   = addr_q;
    assign mem_wmask_o  = mask_q;
    assign mem_wdata_o  = wdata_q;
    assign resp_valid_o = (state == S_DONE);
    assign err_o        = (state == S_ERR);
    assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_bridge.sv
// tb/tb_lsu_bridge.sv - randomized self-checking bench for lsu_bridge
module tb_lsu_bridge;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        hold;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err;
    logic        mem_sel;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    lsu_bridge #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_wen_i    (req_wen),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .hold_o       (hold),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .err_o        (err),
        .mem_sel_o    (mem_sel),
        .mem_wen_o    (mem_wen),
        .mem_addr_o   (mem_addr),
        .mem_wmask_o  (mem_wmask),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .mem_ack_i    (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int m_size(input bit [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input bit wen, input bit [2:0] f3, input bit [31:0] a);
        if (wen) begin
            if (f3 > 3'd2) return 1'b0;
        end else begin
            if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        end
        return (a % m_size(f3)) == 0;
    endfunction

    function automatic bit [3:0] m_mask(input bit [2:0] f3, input bit [31:0] a);
        int sz;
        sz = m_size(f3);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic bit [31:0] m_wdata(input bit [2:0] f3, input bit [31:0] wd);
        bit [31:0] r;
        int        sz;
        sz = m_size(f3);
        r  = 32'd0;
        for (int b = 0; b < 4; b++) begin
            r = r | (((wd >> (8 * (b % sz))) & 32'hFF) << (8 * b));
        end
        return r;
    endfunction

    function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
        longint v;
        longint span;
        int     sz;
        sz   = m_size(f3);
        span = longint'(1) << (8 * sz);
        v    = (longint'(rd) >> (8 * (a % 4))) & (span - 1);
        if ((f3 == 3'd0 || f3 == 3'd1) && (((v >> (8 * sz - 1)) & 1) == 1)) begin
            v = v - span;
        end
        return v[31:0];
    endfunction

    // Issues one request from IDLE (entered at #1 after a rising edge) and
    // checks bus, stall, response and error behaviour against the model.
    task automatic run_req(input bit wen, input bit [2:0] f3, input bit [31:0] a,
                           input bit [31:0] wd, input bit [31:0] rd, input int ack_at);
        bit legal;
        int ncyc;
        int exp_cyc;
        legal = m_legal(wen, f3, a);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        #1;
        chk("hold_accept", 32'(hold), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (!legal) begin
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_no_sel", 32'(mem_sel), 32'd0);
            chk("err_no_resp", 32'(resp_valid), 32'd0);
            chk("err_hold", 32'(hold), 32'd0);
            @(posedge clk);
            #1;
            chk("err_one_cycle", 32'(err), 32'd0);
            return;
        end
        chk("sel", 32'(mem_sel), 32'd1);
        chk("hold_wait", 32'(hold), 32'd1);
        chk("addr", mem_addr, a & 32'hFFFF_FFFC);
        chk("wen", 32'(mem_wen), 32'(wen));
        chk("mask", 32'(mem_wmask), wen ? 32'(m_mask(f3, a)) : 32'd0);
        if (wen) chk("wdata", mem_wdata, m_wdata(f3, wd));
        ncyc = 0;
        while (mem_sel && ncyc < 40) begin
            if (ncyc == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            ncyc++;
        end
        exp_cyc = (ack_at < TIMEOUT) ? ack_at + 1 : TIMEOUT;
        chk("wait_cycles", 32'(ncyc), 32'(exp_cyc));
        chk("hold_fall", 32'(hold), 32'd0);
        if (ack_at < TIMEOUT) begin
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_no_err", 32'(err), 32'd0);
            chk("rdata", resp_rdata, wen ? 32'd0 : m_load(f3, a, rd));
        end else begin
            chk("to_err", 32'(err), 32'd1);
            chk("to_no_resp", 32'(resp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("pulse_end_resp", 32'(resp_valid), 32'd0);
        chk("pulse_end_err", 32'(err), 32'd0);
    endtask

    initial begin
        int        ack_at;
        int        r;
        bit [31:0] a;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_rdata  = 32'd0;
        mem_ack    = 1'b0;
        #22;
        chk("rst_hold", 32'(hold), 32'd0);
        chk("rst_sel", 32'(mem_sel), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_mask", 32'(mem_wmask), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases from the reference scenarios
        run_req(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        run_req(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 1);
        run_req(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 2);
        run_req(1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF_0000, 0);
        run_req(1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF_0000, 0);
        run_req(1'b1, 3'd0, 32'h201, 32'h12345678, 32'h0, 0);
        run_req(1'b1, 3'd1, 32'h202, 32'h12345678, 32'h0, 3);
        run_req(1'b1, 3'd2, 32'h204, 32'h12345678, 32'h0, 0);
        run_req(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0);
        run_req(1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 0);
        run_req(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0);
        run_req(1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 0);
        run_req(1'b0, 3'd2, 32'h300, 32'h0, 32'h1, TIMEOUT);
        run_req(1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, TIMEOUT - 1);

        // Ack while idle must not produce a response
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("idle_ack_resp", 32'(resp_valid), 32'd0);
        chk("idle_ack_sel", 32'(mem_sel), 32'd0);

        // Reset in the third WAIT cycle drops the access immediately
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h400;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_sel", 32'(mem_sel), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_sel", 32'(mem_sel), 32'd0);
        chk("async_rst_hold", 32'(hold), 32'd0);
        chk("async_rst_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("late_ack_resp", 32'(resp_valid), 32'd0);
        chk("late_ack_err", 32'(err), 32'd0);
        chk("late_ack_sel", 32'(mem_sel), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            r = $urandom % 10;
            if (r < 7)      ack_at = $urandom % 4;
            else if (r < 9) ack_at = TIMEOUT - 1;
            else            ack_at = TIMEOUT;
            a = $urandom;
            run_req(1'($urandom % 2), 3'($urandom % 8), a, $urandom, $urandom, ack_at);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
